d_phy_lane_tx: RTL

//  Per-lane D-PHY HS transmitter, directly downstream of the master adapter layer.

---
 rtl/d_phy_pkg.sv | 44 ++++
 rtl/d_phy_lane_timer.sv | 28 ++
 rtl/d_phy_lane_tx.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/d_phy_pkg.sv
// Shared types for the D-PHY lane transmitter: lane FSM states, LP line states
// and the HS sync byte.
package d_phy_pkg;

  typedef enum logic [2:0] {
    STOP,
    HS_RQST,
    HS_PREP,
    HS_ZERO,
    HS_SYNC,
    HS_DATA,
    HS_TRAIL,
    HS_EXIT
  } lane_state_t;

  localparam logic [7:0] D_PHY_SYNC_BYTE = 8'hB8;

  typedef enum logic [1:0] {
    LP11,
    LP01,
    LP00
  } lp_state_t;

  typedef struct packed {
    logic dp;
    logic dn;
  } lp_lines_t;

  // Named LP state to the {dp, dn} line levels; anything unknown parks the lane in LP-11.
  function automatic lp_lines_t lpDecode(input lp_state_t s);
    lp_lines_t lines;
    case (s)
      LP01:    lines = '{dp: 1'b0, dn: 1'b1};
      LP00:    lines = '{dp: 1'b0, dn: 1'b0};
      default: lines = '{dp: 1'b1, dn: 1'b1};
    endcase
    return lines;
  endfunction

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/d_phy_lane_timer.sv
// Loadable down-counter that times each lane state; holds at zero until reloaded.
module d_phy_lane_timer #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] value_o,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign value_o = cnt_q;
  assign zero_o  = (cnt_q == '0);

endmodule

// File: rtl/d_phy_lane_tx.sv
// Per-lane D-PHY HS burst transmitter (LP-11 request, HS-zero, sync, payload, trail, exit).
// Optional statistics counters are built when D_PHY_LANE_STAT_EN is defined.
module d_phy_lane_tx
  import d_phy_pkg::*;
#(
  parameter int T_LPX_CYC        = 4,
  parameter int T_HS_PREPARE_CYC = 3,
  parameter int T_HS_ZERO_CYC    = 10,
  parameter int T_HS_TRAIL_CYC   = 6,
  parameter int T_HS_EXIT_CYC    = 8
) (
  input  logic        hs_clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  input  logic        tx_last,
  output logic        tx_ready,
  output logic        lp_dp,
  output logic        lp_dn,
  output logic        hs_en,
  output logic [7:0]  hs_byte,
  output logic        busy,
  output logic        err_underrun,
  output logic [15:0] stat_bursts,
  output logic [23:0] stat_bytes
);

  localparam int T_MAX = maxInt(maxInt(maxInt(T_LPX_CYC, T_HS_PREPARE_CYC),
                                       maxInt(T_HS_ZERO_CYC, T_HS_TRAIL_CYC)),
                                T_HS_EXIT_CYC);
  localparam int TW = $clog2(T_MAX) + 1;

  localparam logic [TW-1:0] LD_LPX   = TW'(T_LPX_CYC - 1);
  localparam logic [TW-1:0] LD_PREP  = TW'(T_HS_PREPARE_CYC - 1);
  localparam logic [TW-1:0] LD_ZERO  = TW'(T_HS_ZERO_CYC - 1);
  localparam logic [TW-1:0] LD_TRAIL = TW'(T_HS_TRAIL_CYC - 1);
  localparam logic [TW-1:0] LD_EXIT  = TW'(T_HS_EXIT_CYC - 1);

  if (T_LPX_CYC < 1 || T_HS_PREPARE_CYC < 1 || T_HS_ZERO_CYC < 1 ||
      T_HS_TRAIL_CYC < 1 || T_HS_EXIT_CYC < 1) begin : g_badTiming
    $error("d_phy_lane_tx: every T_*_CYC parameter must be >= 1");
  end

  lane_state_t   state_q, state_d;
  logic          txReady_q;
  logic          lpDp_q, lpDn_q;
  logic          hsEn_q;
  logic [7:0]    hsByte_q;
  logic          busy_q;
  logic          errUnderrun_q;
  logic          lastBit_q;

  logic          accept;
  logic          underrun;
  logic          tmrLoad;
  logic [TW-1:0] tmrLoadVal;
  logic [TW-1:0] tmrValue;
  logic          tmrZero;
  lp_state_t     lpNext;

  assign accept = tx_valid & txReady_q;

  d_phy_lane_timer #(
    .W(TW)
  ) u_timer (
    .clk_i      (hs_clk),
    .rst_ni     (rst_n),
    .load_i     (tmrLoad),
    .load_val_i (tmrLoadVal),
    .value_o    (tmrValue),
    .zero_o     (tmrZero)
  );

  // Next state plus the timer reload for whichever timed state is entered next.
  always_comb begin
    state_d    = state_q;
    tmrLoad    = 1'b0;
    tmrLoadVal = '0;
    underrun   = 1'b0;
    case (state_q)
      STOP: begin
        if (en && tx_valid) begin
          state_d    = HS_RQST;
          tmrLoad    = 1'b1;
          tmrLoadVal = LD_LPX;
        end
      end
      HS_RQST: begin
        if (tmrZero) begin
          state_d    = HS_PREP;
          tmrLoad    = 1'b1;
          tmrLoadVal = LD_PREP;
        end
      end
      HS_PREP: begin
        if (tmrZero) begin
          state_d    = HS_ZERO;
          tmrLoad    = 1'b1;
          tmrLoadVal = LD_ZERO;
        end
      end
      HS_ZERO: begin
        if (tmrZero) begin
          state_d = HS_SYNC;
        end
      end
      HS_SYNC: begin
        if (tx_valid) begin
          state_d = HS_DATA;
        end else begin
          underrun   = 1'b1;
          state_d    = HS_TRAIL;
          tmrLoad    = 1'b1;
          tmrLoadVal = LD_TRAIL;
        end
      end
      HS_DATA: begin
        // tx_ready low here means the last byte is on the lane this cycle.
        if (!txReady_q) begin
          state_d    = HS_TRAIL;
          tmrLoad    = 1'b1;
          tmrLoadVal = LD_TRAIL;
        end else if (!tx_valid) begin
          underrun   = 1'b1;
          state_d    = HS_TRAIL;
          tmrLoad    = 1'b1;
          tmrLoadVal = LD_TRAIL;
        end
      end
      HS_TRAIL: begin
        if (tmrZero) begin
          state_d    = HS_EXIT;
          tmrLoad    = 1'b1;
          tmrLoadVal = LD_EXIT;
        end
      end
      HS_EXIT: begin
        if (tmrZero) begin
          state_d = STOP;
        end
      end
      default: begin
        state_d = STOP;
      end
    endcase
  end

  always_comb begin
    case (state_d)
      STOP, HS_EXIT: lpNext = LP11;
      HS_RQST:       lpNext = LP01;
      default:       lpNext = LP00;
    endcase
  end

  always_ff @(posedge hs_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= STOP;
      txReady_q     <= 1'b0;
      lpDp_q        <= 1'b1;
      lpDn_q        <= 1'b1;
      hsEn_q        <= 1'b0;
      hsByte_q      <= 8'h00;
      busy_q        <= 1'b0;
      errUnderrun_q <= 1'b0;
      lastBit_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      busy_q           <= (state_d != STOP);
      hsEn_q           <= (state_d inside {HS_ZERO, HS_SYNC, HS_DATA, HS_TRAIL});
      {lpDp_q, lpDn_q} <= lpDecode(lpNext);
      errUnderrun_q    <= underrun;
      txReady_q        <= (state_d == HS_SYNC) ||
                          ((state_d == HS_DATA) && !(accept && tx_last));
      // Cleared at sync so a burst with no payload trails with 0xFF.
      if (state_d == HS_SYNC) begin
        lastBit_q <= 1'b0;
      end else if (accept) begin
        lastBit_q <= tx_data[7];
      end
      case (state_d)
        HS_SYNC:  hsByte_q <= D_PHY_SYNC_BYTE;
        HS_DATA:  hsByte_q <= tx_data;
        HS_TRAIL: hsByte_q <= {8{~lastBit_q}};
        default:  hsByte_q <= 8'h00;
      endcase
    end
  end

  assert property (@(posedge hs_clk) disable iff (!rst_n) tmrZero == (tmrValue == '0));

`ifdef D_PHY_LANE_STAT_EN
  logic [15:0] statBursts_q;
  logic [23:0] statBytes_q;

  always_ff @(posedge hs_clk or negedge rst_n) begin
    if (!rst_n) begin
      statBursts_q <= '0;
      statBytes_q  <= '0;
    end else begin
      if ((state_d == HS_EXIT) && (state_q != HS_EXIT) && (statBursts_q != '1)) begin
        statBursts_q <= statBursts_q + 1'b1;
      end
      if (accept && (statBytes_q != '1)) begin
        statBytes_q <= statBytes_q + 1'b1;
      end
    end
  end

  assign stat_bursts = statBursts_q;
  assign stat_bytes  = statBytes_q;
`else
  assign stat_bursts = '0;
  assign stat_bytes  = '0;
`endif

  assign tx_ready     = txReady_q;
  assign lp_dp        = lpDp_q;
  assign lp_dn        = lpDn_q;
  assign hs_en        = hsEn_q;
  assign hs_byte      = hsByte_q;
  assign busy         = busy_q;
  assign err_underrun = errUnderrun_q;

endmodule
